// File: rtl/decode_pkg.sv
// Decode package: opcode map, ALU control codes, the decoded-control record
// and the combinational opcode table shared by the decode stage.
package decode_pkg;

    // The opcode table is defined for 5-bit opcodes.
    localparam int OPC_BITS = 5;

    typedef logic [OPC_BITS-1:0] opcode_t;
    typedef logic [2:0]          alu_ctrl_t;

    localparam opcode_t OP_ADD  = 5'b00000;
    localparam opcode_t OP_SUB  = 5'b00010;
    localparam opcode_t OP_ADDI = 5'b00101;
    localparam opcode_t OP_BEQ  = 5'b10011;
    localparam opcode_t OP_BEQF = 5'b10101;
    localparam opcode_t OP_I2CW = 5'b11001;
    localparam opcode_t OP_NOP  = 5'b11111;

    localparam alu_ctrl_t ALU_NOP  = 3'b000;
    localparam alu_ctrl_t ALU_ADD  = 3'b001;
    localparam alu_ctrl_t ALU_SUB  = 3'b010;
    localparam alu_ctrl_t ALU_BEQ  = 3'b011;
    localparam alu_ctrl_t ALU_BEQF = 3'b100;

    // Everything the back end and the hazard logic need to know about one opcode.
    typedef struct packed {
        alu_ctrl_t alu_ctrl;
        logic      rd_wen;    // writes o_dest in the register file
        logic      i2c_ctrl;  // requests an I2C transfer
        logic      uses_src;  // reads the src register (RAW hazard source)
        logic      uses_imm;  // immediate field is forwarded
        logic      illegal;   // unknown opcode, executed as NOP
    } dec_ctrl_t;

    // Combinational opcode table.
    function automatic dec_ctrl_t decode_opcode(input opcode_t opc);
        dec_ctrl_t c;
        // NOTE: every field starts at zero so each path assigns the whole
        // record; a field left unassigned in combinational logic infers a latch.
        c          = '0;
        c.uses_imm = opc[0];
        case (opc)
            OP_ADD: begin
                c.alu_ctrl = ALU_ADD;
                c.rd_wen   = 1'b1;
                c.uses_src = 1'b1;
            end
            OP_SUB: begin
                c.alu_ctrl = ALU_SUB;
                c.rd_wen   = 1'b1;
                c.uses_src = 1'b1;
            end
            OP_ADDI: begin
                c.alu_ctrl = ALU_ADD;
                c.rd_wen   = 1'b1;
            end
            OP_BEQ: begin
                c.alu_ctrl = ALU_BEQ;
                c.uses_src = 1'b1;
            end
            OP_BEQF: begin
                c.alu_ctrl = ALU_BEQF;
            end
            OP_I2CW: begin
                c.i2c_ctrl = 1'b1;
            end
            OP_NOP: begin
                c.alu_ctrl = ALU_NOP;
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

    // Branches and I2C writes carry a target address in the immediate field.
    function automatic logic carries_addr(input dec_ctrl_t c);
        return (c.alu_ctrl == ALU_BEQ) || (c.alu_ctrl == ALU_BEQF) || c.i2c_ctrl;
    endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Decode stage bus: fetch-side handshake, writeback/I2C side inputs and the
// decoded output bundle with its back-end handshake.
interface instr_decode_stage_if #(
    parameter int OPC_W  = 5,
    parameter int REG_W  = 4,
    parameter int IMM_W  = 8,
    parameter int ADDR_W = 8
);
    localparam int INSTR_W = OPC_W + 2 * REG_W + IMM_W;

    // Fetch side
    logic [INSTR_W-1:0] i_instr;
    logic               i_valid;
    logic               o_ready;
    logic               i_flush;

    // Writeback and I2C status
    logic               i_wb_valid;
    logic [REG_W-1:0]   i_wb_reg;
    logic               i_i2c_busy;

    // Back-end side
    logic               o_valid;
    logic               i_ready;
    logic [REG_W-1:0]   o_dest;
    logic [REG_W-1:0]   o_src;
    logic [IMM_W-1:0]   o_imm;
    logic [ADDR_W-1:0]  o_addr;
    logic [2:0]         o_alu_ctrl;
    logic               o_rd_wen;
    logic               o_i2c_ctrl;
    logic               o_illegal;

    // The decode stage itself.
    modport slave (
        input  i_instr, i_valid, i_flush, i_wb_valid, i_wb_reg, i_i2c_busy, i_ready,
        output o_ready, o_valid, o_dest, o_src, o_imm, o_addr, o_alu_ctrl,
               o_rd_wen, o_i2c_ctrl, o_illegal
    );

    // Whoever drives instructions and consumes decoded results.
    modport master (
        output i_instr, i_valid, i_flush, i_wb_valid, i_wb_reg, i_i2c_busy, i_ready,
        input  o_ready, o_valid, o_dest, o_src, o_imm, o_addr, o_alu_ctrl,
               o_rd_wen, o_i2c_ctrl, o_illegal
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one busy bit per register, set when a writer leaves the
// decode stage and cleared when its writeback completes. Two query ports
// report whether a register is busy or reserved by the writer currently held
// in the decode output register.
module reg_scoreboard #(
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_reg,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_reg,
    input  logic             pend_en,
    input  logic [REG_W-1:0] pend_reg,
    input  logic [REG_W-1:0] query_src,
    input  logic [REG_W-1:0] query_dest,
    output logic             src_busy,
    output logic             dest_busy
);
    localparam int NREGS = 1 << REG_W;

    logic [NREGS-1:0] busy;

    // Busy-bit update: set has priority over a same-cycle clear of that register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this vector is reset, unlike a storage RAM: a stale busy bit
        // after reset would stall the pipeline forever.
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                // NOTE: non-blocking assignments keep every bit reading the
                // pre-edge state, so ordering inside this block cannot matter.
                if (set_en && (set_reg == REG_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (clr_en && (clr_reg == REG_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // A writer still held in the output register has not set its bit yet,
    // but its destination is already in flight.
    assign src_busy  = busy[query_src]  || (pend_en && (pend_reg == query_src));
    assign dest_busy = busy[query_dest] || (pend_en && (pend_reg == query_dest));

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage for the OLED sequencer core.
// Splits an instruction into fields, decodes control, stalls on register
// hazards and I2C back-pressure, and holds one decoded entry for the back end.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int OPC_W  = 5,
    parameter int REG_W  = 4,
    parameter int IMM_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    instr_decode_stage_if.slave   bus
);
    localparam int INSTR_W = OPC_W + 2 * REG_W + IMM_W;

    // ---------------------------------------------------------------
    // Field split and decode of the incoming instruction
    // ---------------------------------------------------------------
    logic [INSTR_W-1:0] instr;
    logic [OPC_W-1:0]   f_opc;
    logic [REG_W-1:0]   f_dest;
    logic [REG_W-1:0]   f_src;
    logic [IMM_W-1:0]   f_imm;
    dec_ctrl_t          dec;
    logic [IMM_W-1:0]   imm_d;
    logic [ADDR_W-1:0]  addr_d;

    assign instr                       = bus.i_instr;
    assign {f_opc, f_dest, f_src, f_imm} = instr;
    assign dec                         = decode_opcode(OPC_BITS'(f_opc));
    assign imm_d                       = dec.uses_imm ? f_imm : '0;
    assign addr_d                      = carries_addr(dec) ? f_imm[ADDR_W-1:0] : '0;

    // ---------------------------------------------------------------
    // Output register state
    // ---------------------------------------------------------------
    logic              valid_q;
    logic [REG_W-1:0]  dest_q;
    logic [REG_W-1:0]  src_q;
    logic [IMM_W-1:0]  imm_q;
    logic [ADDR_W-1:0] addr_q;
    alu_ctrl_t         alu_q;
    logic              wen_q;
    logic              i2c_q;
    logic              ill_q;

    // ---------------------------------------------------------------
    // Hazard detection and handshake
    // ---------------------------------------------------------------
    logic src_busy;
    logic dest_busy;
    logic i2c_block;
    logic stall;
    logic ready;
    logic accept;
    logic handoff;

    // Only one I2C transfer may be outstanding: block while the controller
    // is busy or while an I2CW is still waiting at the output.
    assign i2c_block = bus.i_i2c_busy || (valid_q && i2c_q);

    // Illegal opcodes decode with all control zero, so they never stall.
    assign stall = bus.i_valid &&
                   ((dec.uses_src && src_busy)  ||
                    (dec.rd_wen   && dest_busy) ||
                    (dec.i2c_ctrl && i2c_block));

    // Reset level gates ready directly so nothing is accepted while held in reset.
    assign ready   = i_rst_n && (!valid_q || bus.i_ready) && !stall && !bus.i_flush;
    assign accept  = bus.i_valid && ready;
    assign handoff = valid_q && bus.i_ready;

    reg_scoreboard #(
        .REG_W (REG_W)
    ) u_scoreboard (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .set_en     (handoff && wen_q),
        .set_reg    (dest_q),
        .clr_en     (bus.i_wb_valid),
        .clr_reg    (bus.i_wb_reg),
        .pend_en    (valid_q && wen_q),
        .pend_reg   (dest_q),
        .query_src  (f_src),
        .query_dest (f_dest),
        .src_busy   (src_busy),
        .dest_busy  (dest_busy)
    );

    // Output register: load on accept, empty on handoff or flush, hold otherwise.
    // A flush that coincides with a handoff still lets the handoff complete;
    // the scoreboard set above depends only on handoff.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            dest_q  <= '0;
            src_q   <= '0;
            imm_q   <= '0;
            addr_q  <= '0;
            alu_q   <= ALU_NOP;
            wen_q   <= 1'b0;
            i2c_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            dest_q  <= f_dest;
            src_q   <= f_src;
            imm_q   <= imm_d;
            addr_q  <= addr_d;
            alu_q   <= dec.alu_ctrl;
            wen_q   <= dec.rd_wen;
            i2c_q   <= dec.i2c_ctrl;
            ill_q   <= dec.illegal;
        end else if (handoff || bus.i_flush) begin
            valid_q <= 1'b0;
            dest_q  <= '0;
            src_q   <= '0;
            imm_q   <= '0;
            addr_q  <= '0;
            alu_q   <= ALU_NOP;
            wen_q   <= 1'b0;
            i2c_q   <= 1'b0;
            ill_q   <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.o_ready    = ready;
    assign bus.o_valid    = valid_q;
    assign bus.o_dest     = dest_q;
    assign bus.o_src      = src_q;
    assign bus.o_imm      = imm_q;
    assign bus.o_addr     = addr_q;
    assign bus.o_alu_ctrl = alu_q;
    assign bus.o_rd_wen   = wen_q;
    assign bus.o_i2c_ctrl = i2c_q;
    assign bus.o_illegal  = ill_q;

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Parametrised, registered decode stage between instruction fetch and the ALU/register-file/I2C-controller back end of the OLED sequencer core.
- Splits each instruction into opcode, destination, source and immediate fields, then generates ALU, write-enable, branch and I2C control.
- Unlike the current combinational decoder, it is pipelined with a valid/ready handshake and a register scoreboard (RAW/WAW stall).
- Adds flush, illegal-opcode detection and I2C back-pressure.

Parameters:
- OPC_W, 5, opcode field width.
- REG_W, 4, register/flag selector width; 2**REG_W scoreboard entries.
- IMM_W, 8, immediate field width.
- ADDR_W, 8, memory/branch address width; must be <= IMM_W.
- INSTR_W, OPC_W+2*REG_W+IMM_W (21), derived; not overridable.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_instr  in  INSTR_W  instruction. Fields: [INSTR_W-1 -: OPC_W] opcode, next REG_W dest, next REG_W src, low IMM_W imm.
- i_valid  in  1  i_instr valid.
- o_ready  out  1  stage can accept.
- i_flush  in  1  taken branch; discard the held instruction.
- i_wb_valid  in  1  writeback completes.
- i_wb_reg  in  REG_W  register written back.
- i_i2c_busy  in  1  I2C controller busy.
- o_valid  out  1  decoded outputs valid.
- i_ready  in  1  back end accepts.
- o_dest  out  REG_W  destination selector.
- o_src  out  REG_W  source selector.
- o_imm  out  IMM_W  immediate (zero if opcode bit0 = 0).
- o_addr  out  ADDR_W  address: imm[ADDR_W-1:0] for BEQ/BEQF/I2CW, else 0.
- o_alu_ctrl  out  3  000 NOP, 001 ADD, 010 SUB, 011 BEQ, 100 BEQF.
- o_rd_wen  out  1  register write enable.
- o_i2c_ctrl  out  1  I2C transfer request.
- o_illegal  out  1  unknown opcode; decoded as NOP.

Behaviour:
- Reset (async assert, sync release): all outputs 0, scoreboard cleared. o_ready = 0 while i_rst_n is low and 1 afterwards.
- Opcode map:
  - 00000 ADD: alu 001, wen.
  - 00010 SUB: alu 010, wen.
  - 00101 ADDI: alu 001, wen, imm.
  - 10011 BEQ: alu 011.
  - 10101 BEQF: alu 100.
  - 11001 I2CW: i2c_ctrl, imm.
  - 11111 NOP: all control 0.
  - Any other opcode: NOP with o_illegal = 1.
- Output register: one entry, 1-cycle latency. Accept occurs when i_valid && o_ready. Outputs update on the next edge.
- o_ready is combinational: (!o_valid || i_ready) && !stall && !i_flush.
- stall is asserted when any of these hold:
  - the incoming instruction reads a busy src (ADD/SUB/BEQ);
  - it writes a busy dest (WAW);
  - it is I2CW while i_i2c_busy = 1 or an I2CW is held at the output.
- Scoreboard:
  - Busy bit set for o_dest when a wen instruction is handed off (o_valid && i_ready && o_rd_wen).
  - Bit cleared on i_wb_valid for i_wb_reg.
  - Set and clear of the same register in the same cycle: set wins.
  - Clearing a non-busy bit is harmless.
- Held outputs are stable while o_valid && !i_ready.
- o_valid drops the cycle after handoff unless a new accept occurs in the same cycle (back-to-back throughput 1/cycle).
- i_flush: o_valid cleared next edge. No scoreboard set for the flushed instruction. Input not accepted that cycle. Scoreboard bits of already-issued instructions are kept.
- Flush and handoff in the same cycle: the handoff completes (it was accepted downstream); only the new accept is blocked.
- Illegal opcode: passes through as NOP with o_illegal = 1 for one transfer. Never stalls, never touches the scoreboard.
- Reset mid-stall: scoreboard and output register are cleared immediately. Pending writebacks arriving after reset are ignored because the bits are already clear.

Decomposition:
- Package decode_pkg: opcode constants (OP_ADD, OP_SUB, OP_ADDI, OP_BEQ, OP_BEQF, OP_I2CW, OP_NOP), ALU_* 3-bit codes, and a decoded-control struct {alu_ctrl, rd_wen, i2c_ctrl, uses_src, uses_imm, illegal}.
- Sub-module reg_scoreboard (params REG_W): set/clear/query ports, busy vector.
- The combinational opcode table stays a package function.

Test Plan:
- Reset and passthrough:
  - Stimulus: release reset; send ADDI 0x05_3_0_2A with i_ready = 1.
  - Response: o_valid one cycle later; o_dest = 3, o_imm = 0x2A, o_alu_ctrl = 001, o_rd_wen = 1, o_illegal = 0.
- RAW stall:
  - Stimulus: ADDI r3 issued, then ADD dest 1, src 3, with no writeback.
  - Response: o_ready = 0 until i_wb_valid with i_wb_reg = 3; ADD is accepted the cycle after the clear.
- Back-pressure:
  - Stimulus: hold i_ready = 0 for 4 cycles with SUB at the output.
  - Response: outputs stable; o_ready = 0. When i_ready rises, next instruction is accepted; throughput 1/cycle.
- Flush:
  - Stimulus: BEQ held; assert i_flush with i_ready = 0.
  - Response: o_valid = 0 next cycle; scoreboard unchanged; the instruction offered during flush is not accepted.
- I2C back-pressure:
  - Stimulus: I2CW imm 0x3C while i_i2c_busy = 1.
  - Response: stall. After busy drops, o_i2c_ctrl = 1 and o_addr = 0x3C.
- Illegal opcode and mid-operation reset:
  - Stimulus: opcode 01110.
  - Response: o_illegal = 1, o_alu_ctrl = 000, o_rd_wen = 0.
  - Stimulus: assert i_rst_n low mid-stall.
  - Response: all outputs 0 and scoreboard empty immediately.
